// File: rtl/m_axil_cmd_master.sv
// m_axil_cmd_master: single-beat command/response to AXI4-Lite master bridge.
// Accepts one command at a time on CMD_*, runs the matching AXI-Lite write
// (AW+W then B) or read (AR then R) transaction, and returns the outcome on RSP_*.
// Ports:
//   ACLK, ARESETn            clock, asynchronous active-low reset
//   CMD_VALID/READY/WRITE    command handshake and type (1 = write)
//   CMD_ADDR/WDATA/WSTRB     command byte address, write data, byte strobes
//   RSP_VALID/READY          response handshake
//   RSP_WRITE/DATA/RESP      echoed type, read data (0 for writes), BRESP/RRESP
//   AW*, W*, B*, AR*, R*     AXI4-Lite master channels
// All outputs are registered.
module m_axil_cmd_master #(
    parameter int unsigned M_AXI_ADDR_WIDTH = 6,
    parameter int unsigned M_AXI_DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    // command interface
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic                          CMD_WRITE,
    input  logic [M_AXI_ADDR_WIDTH-1:0]   CMD_ADDR,
    input  logic [M_AXI_DATA_WIDTH-1:0]   CMD_WDATA,
    input  logic [M_AXI_DATA_WIDTH/8-1:0] CMD_WSTRB,
    // response interface
    output logic                          RSP_VALID,
    input  logic                          RSP_READY,
    output logic                          RSP_WRITE,
    output logic [M_AXI_DATA_WIDTH-1:0]   RSP_DATA,
    output logic [1:0]                    RSP_RESP,
    // write address channel
    output logic [M_AXI_ADDR_WIDTH-1:0]   AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    // write data channel
    output logic [M_AXI_DATA_WIDTH-1:0]   WDATA,
    output logic [M_AXI_DATA_WIDTH/8-1:0] WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    // write response channel
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    // read address channel
    output logic [M_AXI_ADDR_WIDTH-1:0]   ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    // read data channel
    input  logic [M_AXI_DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WR_B = 3'd2,
        RD_A = 3'd3,
        RD_R = 3'd4,
        RSP  = 3'd5
    } state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;

    // handshakes seen at the coming edge
    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;

    // transaction sequencer; every output is a register of this block
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state     <= IDLE;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_WRITE <= 1'b0;
            RSP_DATA  <= '0;
            RSP_RESP  <= 2'b00;
            AWADDR    <= '0;
            AWVALID   <= 1'b0;
            WDATA     <= '0;
            WSTRB     <= '0;
            WVALID    <= 1'b0;
            BREADY    <= 1'b0;
            ARADDR    <= '0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CMD_VALID && CMD_READY) begin
                        CMD_READY <= 1'b0;
                        if (CMD_WRITE) begin
                            AWADDR  <= CMD_ADDR;
                            WDATA   <= CMD_WDATA;
                            WSTRB   <= CMD_WSTRB;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                            state   <= WR;
                        end else begin
                            ARADDR  <= CMD_ADDR;
                            ARVALID <= 1'b1;
                            state   <= RD_A;
                        end
                    end else begin
                        // also raises CMD_READY on the first edge after reset
                        CMD_READY <= 1'b1;
                    end
                end

                WR: begin
                    // AW and W retire independently, in either order
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        BREADY <= 1'b1;
                        state  <= WR_B;
                    end
                end

                WR_B: begin
                    if (BVALID && BREADY) begin
                        RSP_RESP  <= BRESP;
                        RSP_WRITE <= 1'b1;
                        RSP_DATA  <= '0;
                        BREADY    <= 1'b0;
                        state     <= RSP;
                    end
                end

                RD_A: begin
                    if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_R;
                    end
                end

                RD_R: begin
                    if (RVALID && RREADY) begin
                        RSP_DATA  <= RDATA;
                        RSP_RESP  <= RRESP;
                        RSP_WRITE <= 1'b0;
                        RREADY    <= 1'b0;
                        state     <= RSP;
                    end
                end

                RSP: begin
                    // RSP_VALID rises one cycle after capture, then holds until taken
                    if (!RSP_VALID) begin
                        RSP_VALID <= 1'b1;
                    end else if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
